output_drain_ctrl: RTL and testbench

Downstream drain stage for the pooling array. On a layer-finish pulse it walks every pooled output position in row-major order, one SRAM word at a time. Each word is OUTPUT_SRAM_LEN pixels of BIN_LEN bits. The block issues read row/column requests to the pooling array, captures the returned word and writes it into the output SRAM through a valid/ready write port. It signals done when the whole output tile has been committed.

---
 rtl/output_drain_ctrl_pkg.sv | 37 +++
 rtl/output_drain_ctrl_if.sv | 26 ++
 rtl/output_drain_ctrl_addr_gen.sv | 48 ++++
 rtl/output_drain_ctrl.sv | 108 ++++++++++
 tb/tb_output_drain_ctrl.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/output_drain_ctrl_pkg.sv
// rtl/output_drain_ctrl_pkg.sv - drain FSM states, tile-geometry defaults and derived constants
// Geometry macros normally arrive from sys_defs; the fallbacks keep a standalone build complete.
`ifndef OUTPUT_HEIGHT
`define OUTPUT_HEIGHT 8
`endif
`ifndef OUTPUT_WIDTH
`define OUTPUT_WIDTH 8
`endif
`ifndef OUTPUT_SRAM_LEN
`define OUTPUT_SRAM_LEN 4
`endif
`ifndef BIN_LEN
`define BIN_LEN 8
`endif

package output_drain_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_CAPT,
        S_WRITE,
        S_FIN
    } drain_state_t;

    function automatic int groups_per_row(input int width, input int pix_per_word);
        return width / pix_per_word;
    endfunction

    localparam int GROUPS_PER_ROW = groups_per_row(`OUTPUT_WIDTH, `OUTPUT_SRAM_LEN);

    // Counter width that stays legal for a dimension of 1.
    function automatic int width_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/output_drain_ctrl_if.sv
// rtl/output_drain_ctrl_if.sv - pooling-array read port and output SRAM write port bundle
interface output_drain_ctrl_if #(
    parameter int RW     = 3,
    parameter int CW     = 3,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 12
);
    logic              rd_en;
    logic [RW-1:0]     rd_r;
    logic [CW-1:0]     rd_c;
    logic [DATA_W-1:0] rd_data;
    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    modport master (
        output rd_en, rd_r, rd_c, wr_valid, wr_addr, wr_data,
        input  rd_data, wr_ready
    );

    modport slave (
        input  rd_en, rd_r, rd_c, wr_valid, wr_addr, wr_data,
        output rd_data, wr_ready
    );
endinterface

// File: rtl/output_drain_ctrl_addr_gen.sv
// rtl/output_drain_ctrl_addr_gen.sv - drain_addr_gen: row / column-group / word-index walker
// Walks column groups first, then rows; holds on the last word until cleared.
module drain_addr_gen
    import output_drain_ctrl_pkg::*;
#(
    parameter int ROWS   = 8,
    parameter int GROUPS = 2,
    parameter int PIX    = 4,
    parameter int RW     = 3,
    parameter int CW     = 3,
    parameter int ADDR_W = 12
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clear,
    input  logic              advance,
    output logic [RW-1:0]     row,
    output logic [CW-1:0]     col,
    output logic [ADDR_W-1:0] word_idx,
    output logic              last
);
    localparam int GW = width_of(GROUPS);

    logic [GW-1:0] grp;
    logic          row_last;
    logic          grp_last;

    assign row_last = (row == RW'(ROWS - 1));
    assign grp_last = (grp == GW'(GROUPS - 1));
    assign last     = row_last && grp_last;
    assign col      = CW'(int'(grp) * PIX);

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            row      <= '0;
            grp      <= '0;
            word_idx <= '0;
        end else if (advance && !last) begin
            if (grp_last) begin
                grp <= '0;
                row <= row + 1'b1;
            end else begin
                grp <= grp + 1'b1;
            end
            word_idx <= word_idx + 1'b1;
        end
    end
endmodule

// File: rtl/output_drain_ctrl.sv
// rtl/output_drain_ctrl.sv - drains the pooled tile word by word into the output SRAM
// Optional stall counter enabled by OUTPUT_DRAIN_STALL_CNT_EN.
module output_drain_ctrl
    import output_drain_ctrl_pkg::*;
#(
    parameter int OUTPUT_HEIGHT   = `OUTPUT_HEIGHT,
    parameter int OUTPUT_WIDTH    = `OUTPUT_WIDTH,
    parameter int OUTPUT_SRAM_LEN = `OUTPUT_SRAM_LEN,
    parameter int BIN_LEN         = `BIN_LEN,
    parameter int ADDR_W          = 12
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    output_drain_ctrl_if.master bus,
    output logic              busy,
`ifdef OUTPUT_DRAIN_STALL_CNT_EN
    output logic [31:0]       stall_cycles,
`endif
    output logic              done
);
    localparam int GROUPS = groups_per_row(OUTPUT_WIDTH, OUTPUT_SRAM_LEN);
    localparam int RW     = width_of(OUTPUT_HEIGHT);
    localparam int CW     = width_of(OUTPUT_WIDTH);
    localparam int DATA_W = BIN_LEN * OUTPUT_SRAM_LEN;

    drain_state_t      state, state_next;
    logic [ADDR_W-1:0] base_q;
    logic [DATA_W-1:0] data_q;
    logic [ADDR_W-1:0] word_idx;
    logic [RW-1:0]     row;
    logic [CW-1:0]     col;
    logic              last;
    logic              start_acc;
    logic              handshake;

    assign start_acc = (state == S_IDLE) && start;
    assign handshake = (state == S_WRITE) && bus.wr_ready;

    drain_addr_gen #(
        .ROWS   (OUTPUT_HEIGHT),
        .GROUPS (GROUPS),
        .PIX    (OUTPUT_SRAM_LEN),
        .RW     (RW),
        .CW     (CW),
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clock    (clock),
        .reset    (reset),
        .clear    (start_acc),
        .advance  (handshake),
        .row      (row),
        .col      (col),
        .word_idx (word_idx),
        .last     (last)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (start) state_next = S_READ;
            S_READ:  state_next = S_CAPT;
            S_CAPT:  state_next = S_WRITE;
            S_WRITE: if (bus.wr_ready) state_next = last ? S_FIN : S_READ;
            S_FIN:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // rd_data is only trusted in CAPT, one cycle after the READ request.
    always_ff @(posedge clock) begin
        if (reset) begin
            base_q <= '0;
            data_q <= '0;
        end else begin
            if (start_acc) base_q <= base_addr;
            if (state == S_CAPT) data_q <= bus.rd_data;
        end
    end

    assign bus.rd_en    = (state == S_READ);
    assign bus.rd_r     = row;
    assign bus.rd_c     = col;
    assign bus.wr_valid = (state == S_WRITE);
    assign bus.wr_addr  = base_q + word_idx;
    assign bus.wr_data  = data_q;
    assign busy         = (state != S_IDLE);
    assign done         = (state == S_FIN);

`ifdef OUTPUT_DRAIN_STALL_CNT_EN
    always_ff @(posedge clock) begin
        if (reset || start_acc) begin
            stall_cycles <= '0;
        end else if ((state == S_WRITE) && !bus.wr_ready && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_output_drain_ctrl.sv
// tb/tb_output_drain_ctrl.sv - scoreboard bench for output_drain_ctrl
module tb_output_drain_ctrl;
    localparam int AW    = 12;
    localparam int DW    = 32;
    localparam int WORDS = 16;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic          busy;
    logic          done;
`ifdef OUTPUT_DRAIN_STALL_CNT_EN
    logic [31:0]   stall_cycles;
`endif

    output_drain_ctrl_if #(.RW(3), .CW(3), .DATA_W(DW), .ADDR_W(AW)) bus ();

    output_drain_ctrl dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .base_addr    (base_addr),
        .bus          (bus),
        .busy         (busy),
`ifdef OUTPUT_DRAIN_STALL_CNT_EN
        .stall_cycles (stall_cycles),
`endif
        .done         (done)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    wr_t           exp_q[$];
    int            checks = 0;
    int            errors = 0;
    int            acc_count = 0;
    int            done_count = 0;
    int            rd_count = 0;
    int            busy_cnt = 0;
    int            stall_word = -1;
    int            stall_left = 0;
    logic [7:0]    seed = 8'h00;
    logic [AW-1:0] last_addr = '0;
    logic [DW-1:0] last_data = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Pixel (r,c) of the pooled tile is r*16+c, scrambled by a per-run seed.
    function automatic logic [DW-1:0] model_word(input int r, input int c, input logic [7:0] s);
        logic [DW-1:0] w;
        for (int i = 0; i < 4; i++) w[8*i +: 8] = 8'(r * 16 + c + i) ^ s;
        return w;
    endfunction

    // Pooling array: registered read, floats when not requested.
    always @(posedge clock) begin
        if (bus.rd_en) bus.rd_data <= model_word(int'(bus.rd_r), int'(bus.rd_c), seed);
        else           bus.rd_data <= 'z;
    end

    // SRAM ready driver: optionally stalls one word for stall_left cycles.
    initial bus.wr_ready = 1'b1;
    always @(posedge clock) begin
        #1;
        if (bus.wr_valid && acc_count == stall_word && stall_left > 0) begin
            bus.wr_ready = 1'b0;
            stall_left--;
        end else begin
            bus.wr_ready = 1'b1;
        end
    end

    // Monitor: pops the scoreboard on every accepted write.
    always @(negedge clock) begin
        if (!reset) begin
            if (busy) busy_cnt++;
            if (bus.rd_en) rd_count++;
            if (done) done_count++;
            if (bus.wr_valid && !bus.wr_ready && exp_q.size() > 0) begin
                check("stall_addr", 64'(bus.wr_addr), 64'(exp_q[0].addr));
                check("stall_data", 64'(bus.wr_data), 64'(exp_q[0].data));
                check("stall_rd_en", 64'(bus.rd_en), 64'(0));
            end
            if (bus.wr_valid && bus.wr_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: addr %0h data %0h, expected no write", bus.wr_addr, bus.wr_data);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    check("wr_addr", 64'(bus.wr_addr), 64'(e.addr));
                    check("wr_data", 64'(bus.wr_data), 64'(e.data));
                end
                last_addr = bus.wr_addr;
                last_data = bus.wr_data;
                acc_count++;
            end
        end
    end

    task automatic start_drain(input logic [AW-1:0] base, input logic [7:0] s);
        seed = s;
        acc_count = 0;
        done_count = 0;
        rd_count = 0;
        busy_cnt = 0;
        for (int k = 0; k < WORDS; k++) begin
            wr_t e;
            e.addr = base + AW'(k);
            e.data = model_word(k / 2, (k % 2) * 4, s);
            exp_q.push_back(e);
        end
        start = 1'b1;
        base_addr = base;
        @(posedge clock);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (done_count == 0 && n < 300) begin
            @(posedge clock);
            #1;
            n++;
        end
        if (done_count == 0) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: no done after %0d cycles, expected done", n);
        end
        repeat (3) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic wait_acc(input int target);
        int n;
        n = 0;
        while (acc_count < target && n < 300) begin
            @(posedge clock);
            #1;
            n++;
        end
        if (acc_count < target) begin
            checks++;
            errors++;
            $display("FAIL acc_timeout: %0d writes, expected %0d", acc_count, target);
        end
    endtask

    task automatic check_run(input string tag, input int exp_busy);
        check({tag, "_writes"}, 64'(acc_count), 64'(WORDS));
        check({tag, "_done_cnt"}, 64'(done_count), 64'(1));
        check({tag, "_rd_cnt"}, 64'(rd_count), 64'(WORDS));
        check({tag, "_latency"}, 64'(busy_cnt), 64'(exp_busy));
        check({tag, "_sb_empty"}, 64'(exp_q.size()), 64'(0));
    endtask

    initial begin
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_rd_en", 64'(bus.rd_en), 64'(0));
        check("rst_wr_valid", 64'(bus.wr_valid), 64'(0));
        check("rst_rd_r", 64'(bus.rd_r), 64'(0));
        check("rst_rd_c", 64'(bus.rd_c), 64'(0));
        check("rst_wr_addr", 64'(bus.wr_addr), 64'(0));
        check("rst_wr_data", 64'(bus.wr_data), 64'(0));
`ifdef OUTPUT_DRAIN_STALL_CNT_EN
        check("rst_stall", 64'(stall_cycles), 64'(0));
`endif

        // Basic drain: 16 words, done seen after 49 busy cycles.
        start_drain(12'h100, 8'h00);
        wait_done();
        check_run("basic", 49);
        check("basic_last_addr", 64'(last_addr), 64'h10F);
        check("basic_last_data", 64'(last_data), 64'h77767574);

        // Backpressure on word 3 for 5 cycles.
        stall_word = 3;
        stall_left = 5;
        start_drain(12'h200, 8'h5A);
        wait_done();
        check_run("stall", 54);
`ifdef OUTPUT_DRAIN_STALL_CNT_EN
        check("stall_count", 64'(stall_cycles), 64'(5));
`endif
        stall_word = -1;

        // Address wrap past 0xFFF.
        start_drain(12'hFFE, 8'hA5);
`ifdef OUTPUT_DRAIN_STALL_CNT_EN
        check("stall_cleared", 64'(stall_cycles), 64'(0));
`endif
        wait_done();
        check_run("wrap", 49);
        check("wrap_last_addr", 64'(last_addr), 64'h00D);

        // Second start during word 5 is ignored.
        start_drain(12'h300, 8'h33);
        wait_acc(5);
        start = 1'b1;
        base_addr = 12'h555;
        @(posedge clock);
        #1;
        start = 1'b0;
        wait_done();
        check_run("restart", 49);
        check("restart_last_addr", 64'(last_addr), 64'h30F);

        // Reset while word 7 is in flight, then a clean full drain.
        start_drain(12'h040, 8'h0F);
        wait_acc(7);
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        check("mid_rst_rd_en", 64'(bus.rd_en), 64'(0));
        check("mid_rst_wr_valid", 64'(bus.wr_valid), 64'(0));
        check("mid_rst_busy", 64'(busy), 64'(0));
        check("mid_rst_wr_addr", 64'(bus.wr_addr), 64'(0));
        exp_q.delete();
        repeat (20) begin
            @(posedge clock);
            #1;
        end
        check("mid_rst_no_done", 64'(done_count), 64'(0));
        check("mid_rst_writes", 64'(acc_count), 64'(7));
        start_drain(12'h040, 8'h0F);
        wait_done();
        check_run("after_rst", 49);
        check("after_rst_last_addr", 64'(last_addr), 64'h04F);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
